// File: rtl/gpio_pin_sel_regs.sv
// GPIO pin design-select register bank (Wishbone slave).
//
// Holds a 4-bit design-select code for each of 38 GPIO pins and drives the
// select and oeb-override inputs of the downstream GPIO mux. When a write
// changes a pin's owner, that pin is forced tri-state for a guard interval.
// The new select is then committed, and the pin is released one cycle later.
// This way two designs never drive the same pad at the same time.
//
// Ports:
//   clk_i, nrst_i         clock, asynchronous active-low reset
//   adr_i/dat_i/sel_i     Wishbone byte address, write data, byte enables
//   we_i/cyc_i/stb_i      Wishbone write enable, cycle, strobe
//   ack_o/dat_o           single-cycle acknowledge, registered read data
//   pin_sel_flat          committed select per pin, pin p at [4p+3:4p]
//   force_oeb             per-pin tri-state override to the mux
//   busy_o                a handoff is in progress
module gpio_pin_sel_regs #(
  parameter int unsigned NUM_TEAMS    = 12,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  input  logic [31:0]  adr_i,
  input  logic [31:0]  dat_i,
  input  logic [3:0]   sel_i,
  input  logic         we_i,
  input  logic         cyc_i,
  input  logic         stb_i,
  output logic         ack_o,
  output logic [31:0]  dat_o,
  output logic [151:0] pin_sel_flat,
  output logic [37:0]  force_oeb,
  output logic         busy_o
);

  localparam int unsigned NumPins = 38;
  localparam int unsigned CntW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(GUARD_CYCLES - 1);
  localparam logic [3:0] MaxCode = 4'(NUM_TEAMS);

  typedef enum logic [1:0] {StIdle, StGuard, StCommit} state_e;

  state_e state_q, state_d;

  logic [151:0]    shadow_q, shadow_d;
  logic [151:0]    pin_sel_q, pin_sel_d;
  logic [37:0]     force_q, force_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;

  // Address decode. The low two address bits carry no information for word access.
  logic       in_win, req, sel_word, stall, accept, sel_wr, busy;
  logic [2:0] word;
  logic       unused_adr;

  assign unused_adr = ^adr_i[1:0];
  assign in_win     = (adr_i[31:5] == BASE_ADDR[31:5]);
  assign word       = adr_i[4:2];
  assign req        = cyc_i & stb_i & in_win;
  assign sel_word   = (word <= 3'd4);
  assign busy       = (state_q != StIdle);
  // Select writes wait for the handoff to finish; everything else is serviced.
  assign stall      = we_i & sel_word & busy;
  // ~ack_q keeps a request held through its ack cycle from being acked twice.
  assign accept     = req & ~ack_q & ~stall;
  assign sel_wr     = accept & we_i & sel_word;

  // Shadow merged with the incoming write, and the pins whose owner it changes.
  logic [151:0] merged;
  logic [37:0]  changed;

  for (genvar gp = 0; gp < NumPins; gp++) begin : g_pin
    localparam int unsigned K = gp / 8;
    localparam int unsigned J = gp % 8;
    logic [3:0] field;
    logic       hit;
    assign field = dat_i[4*J +: 4];
    assign hit   = (word == 3'(K)) & sel_i[J/2];
    // Out-of-range codes fall back to the housekeeping design (0).
    assign merged[4*gp +: 4] = hit ? ((field > MaxCode) ? 4'h0 : field)
                                   : shadow_q[4*gp +: 4];
    assign changed[gp] = (merged[4*gp +: 4] != pin_sel_q[4*gp +: 4]);
  end

  // Read mux returns committed selects, never the pending shadow.
  logic [159:0] sel_pad;
  logic [31:0]  rd_data;

  assign sel_pad = {8'h00, pin_sel_q};

  always_comb begin
    rd_data = '0;
    unique case (word)
      3'd0:    rd_data = sel_pad[31:0];
      3'd1:    rd_data = sel_pad[63:32];
      3'd2:    rd_data = sel_pad[95:64];
      3'd3:    rd_data = sel_pad[127:96];
      3'd4:    rd_data = sel_pad[159:128];
      3'd5:    rd_data = {31'b0, busy};
      default: rd_data = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (sel_wr && (|changed)) state_d = StGuard;
      StGuard:  if (cnt_q == '0) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath next state.
  always_comb begin
    shadow_d  = shadow_q;
    pin_sel_d = pin_sel_q;
    force_d   = force_q;
    cnt_d     = cnt_q;
    ack_d     = accept;
    dat_d     = (accept && !we_i) ? rd_data : '0;
    unique case (state_q)
      StIdle: begin
        if (sel_wr) begin
          shadow_d = merged;
          if (|changed) begin
            force_d = force_q | changed;
            cnt_d   = CntLoad;
          end
        end
      end
      StGuard: begin
        // Commit on the way into COMMIT so the new select shows a cycle before release.
        if (cnt_q == '0) begin
          pin_sel_d = shadow_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCommit: force_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      shadow_q  <= '0;
      pin_sel_q <= '0;
      force_q   <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      shadow_q  <= shadow_d;
      pin_sel_q <= pin_sel_d;
      force_q   <= force_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign ack_o        = ack_q;
  assign dat_o        = dat_q;
  assign pin_sel_flat = pin_sel_q;
  assign force_oeb    = force_q;
  assign busy_o       = busy;

endmodule

// File: tb/tb_gpio_pin_sel_regs.sv
// Bench for gpio_pin_sel_regs: directed scenarios followed by random bus traffic.
// The outputs are compared every cycle against a pin-level model of the handoff timeline.
module tb_gpio_pin_sel_regs;

  localparam int unsigned NumTeams = 12;
  localparam int unsigned G        = 4;
  localparam logic [31:0] Base     = 32'h3000_0000;

  logic         clk_i = 1'b0;
  logic         nrst_i = 1'b1;
  logic [31:0]  adr_i = '0;
  logic [31:0]  dat_i = '0;
  logic [3:0]   sel_i = '0;
  logic         we_i = 1'b0;
  logic         cyc_i = 1'b0;
  logic         stb_i = 1'b0;
  logic         ack_o;
  logic [31:0]  dat_o;
  logic [151:0] pin_sel_flat;
  logic [37:0]  force_oeb;
  logic         busy_o;

  gpio_pin_sel_regs #(
    .NUM_TEAMS    (NumTeams),
    .GUARD_CYCLES (G),
    .BASE_ADDR    (Base)
  ) dut (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .adr_i        (adr_i),
    .dat_i        (dat_i),
    .sel_i        (sel_i),
    .we_i         (we_i),
    .cyc_i        (cyc_i),
    .stb_i        (stb_i),
    .ack_o        (ack_o),
    .dat_o        (dat_o),
    .pin_sel_flat (pin_sel_flat),
    .force_oeb    (force_oeb),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;
  int cyc_n   = 0;

  // Model: committed and pending owner per pin, plus the active handoff window.
  logic [3:0]   m_com [38];
  logic [3:0]   m_shd [38];
  logic [37:0]  m_mask;
  bit           m_act;
  int           m_start;
  // Write the model expects the DUT to accept, applied at its ack cycle.
  bit           pw_valid;
  int           pw_cycle;
  logic [2:0]   pw_word;
  logic [31:0]  pw_dat;
  logic [3:0]   pw_sel;
  // Expected outputs for the current cycle.
  logic         exp_busy;
  logic [37:0]  exp_force;
  logic [159:0] exp_pins;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 38; p++) begin
      m_com[p] = 4'h0;
      m_shd[p] = 4'h0;
    end
    m_mask = '0; m_act = 1'b0; m_start = 0; pw_valid = 1'b0;
    exp_busy = 1'b0; exp_force = '0; exp_pins = '0;
  endtask

  task automatic model_write(input logic [2:0] word, input logic [31:0] dat,
                             input logic [3:0] sel);
    int f;
    for (int p = 0; p < 38; p++) begin
      if ((p / 8) == int'(word) && sel[(p % 8) / 2]) begin
        f = int'((dat >> (4 * (p % 8))) & 32'hF);
        m_shd[p] = (f > NumTeams) ? 4'h0 : 4'(f);
      end
    end
    m_mask = '0;
    for (int p = 0; p < 38; p++) m_mask[p] = (m_shd[p] != m_com[p]);
    m_act   = (m_mask != '0);
    m_start = cyc_n;
  endtask

  task automatic model_step();
    // Handoff window is m_start .. m_start+G; the new owner shows from m_start+G.
    if (m_act && cyc_n > m_start + G) begin
      for (int p = 0; p < 38; p++) m_com[p] = m_shd[p];
      m_act  = 1'b0;
      m_mask = '0;
    end
    if (pw_valid && cyc_n == pw_cycle) begin
      pw_valid = 1'b0;
      model_write(pw_word, pw_dat, pw_sel);
    end
    exp_busy  = m_act;
    exp_force = m_act ? m_mask : '0;
    exp_pins  = '0;
    for (int p = 0; p < 38; p++)
      exp_pins[4*p +: 4] = (m_act && cyc_n >= m_start + G) ? m_shd[p] : m_com[p];
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc_n++;
    model_step();
    check_eq("busy", {159'b0, busy_o}, {159'b0, exp_busy});
    check_eq("force_oeb", {122'b0, force_oeb}, {122'b0, exp_force});
    check_eq("pin_sel", {8'b0, pin_sel_flat}, exp_pins);
  endtask

  task automatic bus_idle();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = '0; dat_i = '0; adr_i = '0;
  endtask

  task automatic bus_wr(input logic [2:0] word, input logic [31:0] dat, input logic [3:0] sel);
    int s, t_acc, n;
    s = cyc_n;
    t_acc = s;
    if (word <= 3'd4 && m_act && (m_start + G + 1 > s)) t_acc = m_start + G + 1;
    if (word <= 3'd4) begin
      pw_valid = 1'b1; pw_cycle = t_acc + 1; pw_word = word; pw_dat = dat; pw_sel = sel;
    end
    adr_i = Base + {27'b0, word, 2'b00}; dat_i = dat; sel_i = sel;
    we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack_o && n < 40);
    check_eq("wr_ack_cycle", 160'(cyc_n), 160'(t_acc + 1));
    bus_idle();
    tick();
  endtask

  task automatic bus_rd(input logic [2:0] word, input bit hold, output logic [31:0] d);
    int s, n;
    logic [31:0] e;
    s = cyc_n;
    if (word <= 3'd4) e = exp_pins[32*word +: 32];
    else if (word == 3'd5) e = {31'b0, exp_busy};
    else e = '0;
    adr_i = Base + {27'b0, word, 2'b00}; sel_i = 4'hF;
    we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack_o && n < 40);
    d = dat_o;
    check_eq("rd_ack_cycle", 160'(cyc_n), 160'(s + 1));
    check_eq("rd_data", {128'b0, dat_o}, {128'b0, e});
    if (hold) begin
      tick();
      check_eq("no_reack", {159'b0, ack_o}, 160'b0);
    end
    bus_idle();
    tick();
  endtask

  task automatic bus_abandon(input logic [2:0] word, input logic [31:0] dat,
                             input logic [3:0] sel, input int n);
    adr_i = Base + {27'b0, word, 2'b00}; dat_i = dat; sel_i = sel;
    we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    repeat (n) begin
      tick();
      check_eq("stall_no_ack", {159'b0, ack_o}, 160'b0);
    end
    bus_idle();
    tick();
  endtask

  task automatic bus_outwin(input logic [31:0] adr);
    adr_i = adr; sel_i = 4'hF; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    repeat (4) begin
      tick();
      check_eq("outwin_no_ack", {159'b0, ack_o}, 160'b0);
    end
    bus_idle();
    tick();
  endtask

  task automatic do_reset();
    nrst_i = 1'b0;
    model_reset();
    #1;
    check_eq("rst_force", {122'b0, force_oeb}, 160'b0);
    check_eq("rst_busy", {159'b0, busy_o}, 160'b0);
    check_eq("rst_ack", {159'b0, ack_o}, 160'b0);
    check_eq("rst_pins", {8'b0, pin_sel_flat}, 160'b0);
    tick();
    tick();
    nrst_i = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [2:0]  w;
    model_reset();
    bus_idle();
    #2;
    do_reset();
    tick();

    // Reset state readback.
    for (int k = 0; k < 6; k++) begin
      bus_rd(3'(k), 1'b0, d);
      check_eq("reset_rd", {128'b0, d}, 160'b0);
    end

    // Basic write: pins 0/1 hand off, STATUS read mid-handoff held through ack.
    bus_wr(3'd0, 32'h0000_0035, 4'hF);
    check_eq("sel0_force", {122'b0, force_oeb}, 160'h3);
    bus_rd(3'd5, 1'b1, d);
    check_eq("status_busy", {128'b0, d}, 160'h1);
    check_eq("sel0_commit", {152'b0, pin_sel_flat[7:0]}, 160'h35);
    check_eq("sel0_force_last", {122'b0, force_oeb}, 160'h3);
    tick();
    check_eq("sel0_release", {122'b0, force_oeb}, 160'h0);

    // Out-of-range codes stored as 0: no change, no tri-state.
    bus_wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    repeat (6) tick();

    // Byte-enabled write to SEL4.
    bus_wr(3'd4, 32'hCCCC_CCCC, 4'b0010);
    check_eq("sel4_force", {122'b0, force_oeb}, 160'h0C_0000_0000);
    repeat (6) tick();
    bus_rd(3'd4, 1'b0, d);
    check_eq("sel4_rb", {128'b0, d}, 160'h0000_CC00);

    // Write during handoff stalls; STATUS serviced meanwhile.
    bus_wr(3'd0, 32'h0000_0077, 4'h1);
    bus_rd(3'd5, 1'b0, d);
    check_eq("status_busy2", {128'b0, d}, 160'h1);
    bus_wr(3'd2, 32'h1234_5678, 4'hF);
    repeat (8) tick();

    // Abandoned stalled write leaves no trace.
    bus_wr(3'd3, 32'h0000_0001, 4'h1);
    bus_abandon(3'd3, 32'h9999_9999, 4'hF, 2);
    repeat (8) tick();
    bus_rd(3'd3, 1'b0, d);
    check_eq("abandon_rb", {128'b0, d}, 160'h1);

    bus_outwin(Base + 32'h20);
    bus_outwin(Base - 32'h4);

    // Reset mid-guard discards the pending select.
    bus_wr(3'd1, 32'h1111_1111, 4'hF);
    do_reset();
    repeat (8) tick();
    check_eq("post_rst_pins", {8'b0, pin_sel_flat}, 160'b0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      w = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) bus_wr(w, $urandom, 4'($urandom_range(0, 15)));
      else bus_rd(w, 1'b0, d);
      repeat ($urandom_range(0, 6)) tick();
    end
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
